line_buffer_3row: RTL and testbench
===================================

LINE_BUFFER_3ROW -- requirements
Module: line_buffer_3row

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the pixel width in bits.
REQ-002 The block SHALL have parameter IMG_WIDTH, default 640, the pixels per image line.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 10, the column counter width; it SHALL satisfy 2^ADDR_WIDTH >= IMG_WIDTH.
REQ-004 clk  input  1  pixel clock; the only clock.
REQ-005 reset_n  input  1  reset, synchronous to clk, active-low.
REQ-006 sof_in  input  1  start-of-frame pulse, sampled on the rising edge of clk.
REQ-007 data_in_valid  input  1  data_in carries a pixel this cycle.
REQ-008 data_in  input  DATA_WIDTH  input pixel, raster order.
REQ-009 data0_out  output  DATA_WIDTH  pixel at the same column two lines above the current line (oldest).
REQ-010 data1_out  output  DATA_WIDTH  pixel at the same column one line above the current line.
REQ-011 data2_out  output  DATA_WIDTH  current pixel.
REQ-012 data_out_valid  output  1  data0/1/2_out form a valid 3-pixel column; this output feeds the downstream 3-input sorter.

Function
REQ-013 The block SHALL contain two line memories, line0_mem and line1_mem, each IMG_WIDTH x DATA_WIDTH.
REQ-014 The block SHALL keep col_cnt (ADDR_WIDTH bits) and row_cnt (2 bits, saturating at 2).
REQ-015 On an accepted pixel (data_in_valid=1), at col=col_cnt, the block SHALL:
- read line1_mem[col] and line0_mem[col] (old contents);
- write line1_mem[col]<=data_in;
- write line0_mem[col]<=old line1_mem[col].
REQ-016 On an accepted pixel, the block SHALL register data2_out<=data_in, data1_out<=old line1_mem[col], data0_out<=old line0_mem[col]; latency from input to output SHALL be exactly 1 clk.
REQ-017 col_cnt SHALL increment on each accepted pixel; at IMG_WIDTH-1 it SHALL wrap to 0 and row_cnt SHALL increment, saturating at 2.
REQ-018 data_out_valid SHALL be registered as (data_in_valid AND row_cnt==2); the value of row_cnt used is the one before the update in that same cycle.
REQ-019 When data_in_valid=0, the block SHALL hold the counters, memories and data outputs, and SHALL drive data_out_valid to 0 next cycle.
REQ-020 sof_in=1 SHALL clear col_cnt and row_cnt.
REQ-021 If sof_in and data_in_valid are both 1, the pixel SHALL be processed as column 0 of row 0: after that cycle col_cnt=1 and row_cnt=0, and data_out_valid=0 next cycle.
REQ-022 sof_in SHALL NOT clear the memories; stale contents SHALL never appear with data_out_valid=1.
REQ-023 Back-to-back valid pixels at one per clk SHALL be supported with no stall; the block SHALL have no backpressure.

Reset
REQ-024 While reset_n=0 at a clk edge, the block SHALL set col_cnt=0, row_cnt=0, data0_out=0, data1_out=0, data2_out=0 and data_out_valid=0.
REQ-025 Line memories SHALL NOT be reset.
REQ-026 A reset mid-line SHALL discard partial-line state; the next accepted pixel SHALL be column 0 of row 0.
REQ-027 reset_n=0 SHALL take priority over sof_in and data_in_valid.

Verification (IMG_WIDTH=4, DATA_WIDTH=8)
REQ-028 Reset then idle -> all outputs 0; data_out_valid=0.
REQ-029 Stream pixels 1..12 continuously (rows {1,2,3,4}, {5,6,7,8}, {9,10,11,12}) -> data_out_valid=0 for pixels 1..8, then =1 for 4 cycles with (data0,data1,data2) = (1,5,9), (2,6,10), (3,7,11), (4,8,12), each 1 clk after its input.
REQ-030 Continue with pixels 13..16 -> (5,9,13), (6,10,14), (7,11,15), (8,12,16), all valid.
REQ-031 Apply data_in_valid=0 gaps of 1-3 cycles inside rows -> same output sequence as REQ-029; data_out_valid=0 in gap cycles; data outputs hold their last value.
REQ-032 Apply sof_in coincident with the first pixel 100 after a full frame -> next 8 pixels give data_out_valid=0; the 9th pixel's column gives data0=100.
REQ-033 Apply reset_n=0 after pixel 6, then stream 20..31 -> first valid output = (20,24,28); no pre-reset data appears with data_out_valid=1.

Source files
------------

// File: rtl/line_buffer_3row.sv
// line_buffer_3row: three-row pixel column former for a 3x3 style window.
// Two line memories hold the previous two image lines. For each accepted
// pixel the block emits the pixel itself plus the pixels at the same column
// one and two lines above, one clock later.
module line_buffer_3row #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sof_in,
  input  logic                  data_in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data0_out,
  output logic [DATA_WIDTH-1:0] data1_out,
  output logic [DATA_WIDTH-1:0] data2_out,
  output logic                  data_out_valid
);

  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(IMG_WIDTH - 1);

  logic [DATA_WIDTH-1:0] line0_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] line1_mem [IMG_WIDTH];

  logic [ADDR_WIDTH-1:0] col_cnt;
  logic [1:0]            row_cnt;

  logic [ADDR_WIDTH-1:0] col;
  logic [1:0]            row;
  logic [DATA_WIDTH-1:0] line0_rd;
  logic [DATA_WIDTH-1:0] line1_rd;
  logic                  accept;
  logic                  last_col;

  // Effective position of this cycle's pixel: a start-of-frame pulse forces
  // it to column 0 of row 0, and the old line contents at that column.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    col      = col_cnt;
    row      = row_cnt;
    if (sof_in) begin
      col = '0;
      row = '0;
    end
    line0_rd = line0_mem[col];
    line1_rd = line1_mem[col];
    accept   = reset_n && data_in_valid;
    last_col = (col == LAST_COL);
  end

  // Line memories: shift the column down one line on each accepted pixel.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are deliberately not reset; the row counter keeps
    // stale contents from ever being flagged valid, and a reset port would
    // prevent mapping onto RAM.
    if (accept) begin
      line1_mem[col] <= data_in;
      line0_mem[col] <= line1_rd;
    end
  end

  // Column/row position tracking; row count saturates once two full lines
  // are buffered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (data_in_valid) begin
      if (last_col) begin
        col_cnt <= '0;
        row_cnt <= (row == 2'd2) ? 2'd2 : row + 2'd1;
      end else begin
        col_cnt <= col + ADDR_WIDTH'(1);
        row_cnt <= row;
      end
    end else if (sof_in) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end
  end

  // Output column register: one clock after the accepted pixel; holds
  // through idle cycles, with valid only once two prior lines exist.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data0_out      <= '0;
      data1_out      <= '0;
      data2_out      <= '0;
      data_out_valid <= 1'b0;
    end else if (data_in_valid) begin
      data0_out      <= line0_rd;
      data1_out      <= line1_rd;
      data2_out      <= data_in;
      data_out_valid <= (row == 2'd2);
    end else begin
      data_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_buffer_3row.sv
// tb_line_buffer_3row: directed and randomized stimulus for line_buffer_3row
// against a frame-level reference model (pixels stored by row/column).
module tb_line_buffer_3row;

  localparam int DW = 8;
  localparam int W  = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sof_in;
  logic          data_in_valid;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data0_out;
  logic [DW-1:0] data1_out;
  logic [DW-1:0] data2_out;
  logic          data_out_valid;

  int total = 0;
  int bad   = 0;

  // Reference model: pixel r,c of the current frame lives in pix[r%4][c].
  int            r, c;
  logic [DW-1:0] pix [4][W];
  logic [DW-1:0] ed0, ed1, ed2;
  logic          ev;
  logic          known01;
  int            nvalid;

  line_buffer_3row #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .ADDR_WIDTH(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sof_in         (sof_in),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .data0_out      (data0_out),
    .data1_out      (data1_out),
    .data2_out      (data2_out),
    .data_out_valid (data_out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, update the model, then check outputs.
  task automatic step(input logic s, input logic v, input logic [DW-1:0] d);
    if (v) begin
      if (s) begin
        r = 0;
        c = 0;
      end
      ev  = (r >= 2);
      ed2 = d;
      known01 = (r >= 2);
      if (r >= 2) begin
        ed1 = pix[(r-1)%4][c];
        ed0 = pix[(r-2)%4][c];
      end
      pix[r%4][c] = d;
      c++;
      if (c == W) begin
        c = 0;
        r++;
      end
    end else begin
      ev = 1'b0;
      if (s) begin
        r = 0;
        c = 0;
      end
    end
    sof_in        = s;
    data_in_valid = v;
    data_in       = d;
    @(posedge clk);
    #1;
    chk("valid", data_out_valid, ev);
    chk("data2", data2_out, ed2);
    if (known01) begin
      chk("data1", data1_out, ed1);
      chk("data0", data0_out, ed0);
    end
    if (data_out_valid === 1'b1) nvalid++;
  endtask

  // Reset cycle with random other inputs to confirm reset priority.
  task automatic do_reset();
    reset_n       = 1'b0;
    sof_in        = 1'($urandom);
    data_in_valid = 1'($urandom);
    data_in       = DW'($urandom);
    @(posedge clk);
    #1;
    r = 0; c = 0;
    ev = 0; ed0 = 0; ed1 = 0; ed2 = 0; known01 = 1'b1;
    chk("rst_valid", data_out_valid, 1'b0);
    chk("rst_data0", data0_out, 0);
    chk("rst_data1", data1_out, 0);
    chk("rst_data2", data2_out, 0);
    reset_n       = 1'b1;
    sof_in        = 1'b0;
    data_in_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; sof_in = 1'b0; data_in_valid = 1'b0; data_in = '0;
    nvalid = 0;
    @(posedge clk);
    #1;
    do_reset();
    // Reset then idle: everything stays at zero.
    repeat (3) step(1'b0, 1'b0, DW'($urandom));

    // Continuous stream 1..16: valid from pixel 9 onward.
    nvalid = 0;
    for (int p = 1; p <= 16; p++) step(1'b0, 1'b1, DW'(p));
    chk("stream_valid_count", nvalid, 8);

    // Fresh frame 1..12 with 1-3 cycle gaps inside rows.
    nvalid = 0;
    for (int p = 1; p <= 12; p++) begin
      step(p == 1, 1'b1, DW'(p));
      if (p % 4 != 0 && ($urandom_range(0, 1) == 1))
        repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, DW'($urandom));
    end
    chk("gap_valid_count", nvalid, 4);

    // New frame starting with sof coincident with pixel 100.
    nvalid = 0;
    for (int p = 0; p < 12; p++) step(p == 0, 1'b1, DW'(100 + p));
    chk("sof_valid_count", nvalid, 4);

    // Reset after pixel 6 of a frame, then stream 20..31.
    for (int p = 1; p <= 6; p++) step(p == 1, 1'b1, DW'(p + 50));
    do_reset();
    nvalid = 0;
    for (int p = 20; p <= 31; p++) step(1'b0, 1'b1, DW'(p));
    chk("post_rst_valid_count", nvalid, 4);

    // Randomized traffic: random gaps, data, occasional sof and reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, DW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
